// File: rtl/sorted_stream_reader.sv
// Sweeps the sorter read port from address 0 and emits its valid entries as an ascending valid/ready stream.
// Two-cycle read latency into a 2-entry buffer; head held stable until accepted, reads pause when the buffer is full.
module sorted_stream_reader #(
  parameter int ELEMENTS    = 64,
  parameter int BIT_WIDTH   = 32,
  parameter int INDEX_WIDTH = 32,
  localparam int AW         = $clog2(ELEMENTS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sorter_last,
  output logic [AW-1:0]            sorter_address,
  input  logic                     sorter_valid,
  input  logic [BIT_WIDTH-1:0]     sorter_data,
  input  logic [2*INDEX_WIDTH-1:0] sorter_meta,
  input  logic [AW:0]              limit,
  input  logic                     restart,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [BIT_WIDTH-1:0]     m_data,
  output logic [2*INDEX_WIDTH-1:0] m_meta,
  output logic                     m_last,
  output logic                     busy,
  output logic                     done,
  output logic [AW:0]              emit_count
);

  typedef struct packed {
    logic [INDEX_WIDTH-1:0] id1;
    logic [INDEX_WIDTH-1:0] id0;
  } id_pair_s;

  typedef struct packed {
    logic [BIT_WIDTH-1:0] data;
    id_pair_s             meta;
  } entry_t;

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_e;

  state_e      state_q, state_d;
  entry_t      slot_q [2];
  logic        wr_ptr_q, rd_ptr_q;
  logic [1:0]  count_q, count_nx;
  // rd_pend_q: address on the sorter port this cycle; rd_ret_q: its result is on sorter_* now
  logic        rd_pend_q, rd_ret_q;
  logic [AW:0] next_addr_q, accepted_q, acc_nx, lim_q;
  logic        push, pop, start, issue, inv_ret, lim_hit;

  assign busy    = (state_q == SWEEP) || (state_q == DRAIN);
  assign done    = (state_q == DONE);
  assign m_valid = busy && ((count_q == 2'd2) ||
                   ((state_q == DRAIN) && !rd_pend_q && !rd_ret_q && (count_q != 2'd0)));
  assign m_last  = (state_q == DRAIN) && !rd_pend_q && !rd_ret_q && (count_q == 2'd1);
  assign m_data  = slot_q[rd_ptr_q].data;
  assign m_meta  = slot_q[rd_ptr_q].meta;

  assign push     = busy && rd_ret_q && sorter_valid;
  assign pop      = m_valid && m_ready;
  assign count_nx = count_q + {1'b0, push} - {1'b0, pop};
  assign acc_nx   = accepted_q + (AW+1)'(push);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    issue   = 1'b0;
    inv_ret = 1'b0;
    lim_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (sorter_last) begin
          start   = 1'b1;
          state_d = (ELEMENTS == 1) ? DRAIN : SWEEP;
        end
      end
      SWEEP: begin
        // the sorter packs valid entries from slot 0, so the first empty slot ends the sweep
        inv_ret = rd_ret_q && !sorter_valid;
        lim_hit = (lim_q != '0) && (acc_nx == lim_q);
        issue   = !inv_ret && !lim_hit && !rd_pend_q && (count_nx < 2'd2);
        if (inv_ret || lim_hit || (issue && (next_addr_q == (AW+1)'(ELEMENTS - 1))))
          state_d = DRAIN;
      end
      DRAIN: begin
        if ((count_q == 2'd0) && !rd_pend_q && !rd_ret_q) state_d = DONE;
      end
      DONE: begin
        if (restart) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sorter_address <= '0;
      next_addr_q    <= '0;
      accepted_q     <= '0;
      lim_q          <= '0;
      emit_count     <= '0;
      rd_pend_q      <= 1'b0;
      rd_ret_q       <= 1'b0;
      count_q        <= 2'd0;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      for (int i = 0; i < 2; i++) slot_q[i] <= '0;
    end else begin
      rd_ret_q  <= rd_pend_q;
      rd_pend_q <= start || issue;
      count_q   <= count_nx;
      if (start) begin
        sorter_address <= '0;
        next_addr_q    <= (AW+1)'(1);
        lim_q          <= limit;
        accepted_q     <= '0;
        emit_count     <= '0;
      end else if (issue) begin
        sorter_address <= next_addr_q[AW-1:0];
        next_addr_q    <= next_addr_q + (AW+1)'(1);
      end
      if (push) begin
        slot_q[wr_ptr_q] <= {sorter_data, sorter_meta};
        wr_ptr_q         <= ~wr_ptr_q;
        accepted_q       <= acc_nx;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
        if (emit_count < (AW+1)'(ELEMENTS)) emit_count <= emit_count + (AW+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_sorted_stream_reader.sv
// Scoreboarded bench for sorted_stream_reader with a synchronous-read sorter model (ELEMENTS=8).
module tb_sorted_stream_reader;
  localparam int EL = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sorter_last = 1'b0;
  logic [AW-1:0] sorter_address;
  logic          sorter_valid;
  logic [31:0]   sorter_data;
  logic [63:0]   sorter_meta;
  logic [AW:0]   limit = '0;
  logic          restart = 1'b0;
  logic          m_valid, m_ready, m_last, busy, done;
  logic [31:0]   m_data;
  logic [63:0]   m_meta;
  logic [AW:0]   emit_count;

  logic          ready_fix = 1'b1;
  logic          rand_ready = 1'b0;
  logic          rnd_bit = 1'b1;
  assign m_ready = rand_ready ? rnd_bit : ready_fix;

  sorted_stream_reader #(.ELEMENTS(EL), .BIT_WIDTH(32), .INDEX_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .sorter_last(sorter_last), .sorter_address(sorter_address),
    .sorter_valid(sorter_valid), .sorter_data(sorter_data), .sorter_meta(sorter_meta),
    .limit(limit), .restart(restart), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_meta(m_meta), .m_last(m_last), .busy(busy), .done(done),
    .emit_count(emit_count)
  );

  always #5 clk = ~clk;

  // sorter model: registered read, valid for slots below n_valid
  logic [31:0] mk [EL];
  logic [63:0] mm [EL];
  int          n_valid = 0;
  always @(posedge clk) begin
    sorter_valid <= (int'(sorter_address) < n_valid);
    sorter_data  <= mk[sorter_address];
    sorter_meta  <= mm[sorter_address];
  end

  always @(posedge clk) begin
    #1 rnd_bit = 1'($urandom_range(0, 1));
  end

  typedef struct packed {
    logic [31:0] d;
    logic [63:0] m;
    logic        l;
  } beat_t;

  beat_t sb[$];
  int    n_cmp = 0;
  int    n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // monitor: pops the scoreboard on each handshake, checks hold while stalled
  logic          stall_prev = 1'b0;
  beat_t         held;
  int            beats = 0;
  int            saw_valid = 0;
  int            max_addr = 0;
  bit            wrapped = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic          prev_busy = 1'b0;
  always @(negedge clk) begin
    beat_t exp_b;
    if (!rst_n) begin
      stall_prev = 1'b0;
      prev_busy  = 1'b0;
    end else begin
      if (busy && !prev_busy) begin
        max_addr = int'(sorter_address);
        wrapped  = 1'b0;
      end
      if (busy && int'(sorter_address) > max_addr) max_addr = int'(sorter_address);
      if (busy && prev_busy && sorter_address == '0 && prev_addr != '0) wrapped = 1'b1;
      if (m_valid) saw_valid++;
      if (stall_prev) check("stall_hold", {m_valid, m_data, m_meta, m_last}, {1'b1, held});
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_beat: actual=%0h required=none", m_data);
        end else begin
          exp_b = sb.pop_front();
          check("beat", {m_data, m_meta, m_last}, exp_b);
          beats++;
        end
      end
      stall_prev = m_valid && !m_ready;
      held       = {m_data, m_meta, m_last};
      prev_addr  = sorter_address;
      prev_busy  = busy;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_entry(input int i, input logic [31:0] key, input logic [31:0] idx);
    mk[i] = key;
    mm[i] = {key, idx};
  endtask

  task automatic expect_beat(input logic [31:0] key, input logic [31:0] idx, input logic last);
    sb.push_back({key, {key, idx}, last});
  endtask

  task automatic go_idle();
    sorter_last = 1'b0;
    if (done) begin
      restart = 1'b1;
      step(1);
      restart = 1'b0;
    end
    step(1);
  endtask

  task automatic wait_done(input string name, input int budget, output int cyc);
    cyc = 0;
    while (!done && cyc < budget) begin
      step(1);
      cyc++;
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: actual=not_done required=done", name);
    end
    step(1);
  endtask

  // T1 data: loaded 7,3,9,1,5 at indices 0..4, meta = {key, load index}
  task automatic load_t1();
    set_entry(0, 1, 3);
    set_entry(1, 3, 1);
    set_entry(2, 5, 4);
    set_entry(3, 7, 0);
    set_entry(4, 9, 2);
    n_valid = 5;
  endtask

  task automatic expect_t1();
    expect_beat(1, 3, 1'b0);
    expect_beat(3, 1, 1'b0);
    expect_beat(5, 4, 1'b0);
    expect_beat(7, 0, 1'b0);
    expect_beat(9, 2, 1'b1);
  endtask

  task automatic run_t1(input string name);
    int cyc;
    int b0;
    b0 = beats;
    load_t1();
    expect_t1();
    limit       = '0;
    sorter_last = 1'b1;
    wait_done(name, 400, cyc);
    check({name, "_emit"}, emit_count, 4'd5);
    check({name, "_beats"}, beats - b0, 5);
    check({name, "_sb_empty"}, sb.size(), 0);
  endtask

  initial begin
    int cyc;
    int b0;
    int v0;
    for (int i = 0; i < EL; i++) begin
      mk[i] = '0;
      mm[i] = '0;
    end
    #1;
    check("reset_outputs", {m_valid, m_last, busy, done, emit_count, sorter_address},
          {1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0});
    #20 rst_n = 1'b1;
    step(2);
    check("idle_no_start", {busy, done}, 2'b00);

    // T1: basic sweep, m_ready held high
    run_t1("t1");
    check("t1_done", done, 1'b1);

    // T2: same data, random backpressure
    go_idle();
    rand_ready = 1'b1;
    run_t1("t2");
    rand_ready = 1'b0;

    // T3: keys 8..1 loaded, limit 3
    go_idle();
    for (int i = 0; i < EL; i++) set_entry(i, 32'(i + 1), 32'(7 - i));
    n_valid = 8;
    expect_beat(1, 7, 1'b0);
    expect_beat(2, 6, 1'b0);
    expect_beat(3, 5, 1'b1);
    b0 = beats;
    limit = 4'd3;
    sorter_last = 1'b1;
    wait_done("t3", 400, cyc);
    check("t3_emit", emit_count, 4'd3);
    check("t3_beats", beats - b0, 3);
    check("t3_max_addr", max_addr, 2);
    check("t3_sb_empty", sb.size(), 0);

    // T4: empty sorter
    go_idle();
    n_valid = 0;
    limit = '0;
    v0 = saw_valid;
    sorter_last = 1'b1;
    wait_done("t4", 20, cyc);
    check("t4_latency_ok", cyc <= 5, 1'b1);
    check("t4_no_valid", saw_valid - v0, 0);
    check("t4_emit", emit_count, 4'd0);

    // T5: full sorter, keys 0..7 loaded in reverse
    go_idle();
    for (int i = 0; i < EL; i++) begin
      set_entry(i, 32'(i), 32'(7 - i));
      expect_beat(32'(i), 32'(7 - i), i == EL - 1);
    end
    n_valid = 8;
    b0 = beats;
    sorter_last = 1'b1;
    wait_done("t5", 400, cyc);
    check("t5_emit", emit_count, 4'd8);
    check("t5_beats", beats - b0, 8);
    check("t5_no_wrap", wrapped, 1'b0);
    check("t5_max_addr", max_addr, 7);
    check("t5_sb_empty", sb.size(), 0);

    // T6: reset in the middle of a stalled sweep
    go_idle();
    load_t1();
    ready_fix = 1'b0;
    sorter_last = 1'b1;
    step(6);
    check("t6_busy_before_reset", {busy, m_valid}, 2'b11);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_reset_outputs", {m_valid, m_last, busy, done, emit_count, sorter_address, m_data, m_meta},
          {1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 32'd0, 64'd0});
    sorter_last = 1'b0;
    ready_fix = 1'b1;
    step(2);
    rst_n = 1'b1;
    step(1);
    run_t1("t6_rerun");

    // restart with sorter_last still high repeats the sweep
    expect_t1();
    b0 = beats;
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    wait_done("t6_restart", 400, cyc);
    check("t6_restart_emit", emit_count, 4'd5);
    check("t6_restart_beats", beats - b0, 5);
    check("t6_restart_sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
